mbinit_repairmb_responder: RTL and testbench

Partner-side (responder) sequencer for the MBINIT.REPAIRMB handshake, parametrised in lane count, retry depth and response timeout. Answers the remote start/apply-degrade/end requests over the sideband and validates each degrade request against local per-lane results. On a failed check it drives the local repeater a bounded number of times, and it raises a train error on exhaustion, an illegal width code, or a request timeout. It sits in LTSM/MBINIT after REVERSALMB and feeds the RX width-degrade logic.

---
 rtl/mbinit_repairmb_responder_if.sv | 24 ++
 rtl/mbinit_repairmb_responder.sv | 149 ++++++++++++++
 tb/tb_mbinit_repairmb_responder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbinit_repairmb_responder_if.sv
// Sideband handshake bundle between the REPAIRMB responder and the sideband
// TX/RX blocks. The master side drives decoded RX traffic and TX status. The
// slave side (the responder) drives the outgoing message.
interface mbinit_repairmb_responder_if;
    logic       i_busy_sideband;
    logic       i_falling_edge_busy;
    logic [3:0] i_rx_sb_message;
    logic       i_msg_valid;
    logic [1:0] i_rx_functional_lanes;
    logic       o_valid_out;
    logic [3:0] o_tx_sb_message;

    modport master (
        output i_busy_sideband, i_falling_edge_busy, i_rx_sb_message,
               i_msg_valid, i_rx_functional_lanes,
        input  o_valid_out, o_tx_sb_message
    );

    modport slave (
        input  i_busy_sideband, i_falling_edge_busy, i_rx_sb_message,
               i_msg_valid, i_rx_functional_lanes,
        output o_valid_out, o_tx_sb_message
    );
endinterface

// File: rtl/mbinit_repairmb_responder.sv
// MBINIT.REPAIRMB responder. It answers start, apply-degrade and end requests
// from the partner and checks each requested width against the local lane
// results. It retries through the repeater a bounded number of times. It
// flags a train error on exhaustion, on an illegal width, or on a request
// timeout.
module mbinit_repairmb_responder #(
    parameter int NUM_LANES      = 16,
    parameter int MAX_REPEATS    = 2,
    parameter int TIMEOUT_CYCLES = 8000,
    localparam int RCW = (MAX_REPEATS > 0) ? $clog2(MAX_REPEATS + 1) : 1
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 i_enable,
    mbinit_repairmb_responder_if.slave sb,
    input  logic [NUM_LANES-1:0] i_lane_pass,
    input  logic                 i_done_repeater,
    output logic                 o_start_repeater,
    output logic [1:0]           o_functional_lanes,
    output logic [NUM_LANES-1:0] o_lane_mask,
    output logic [RCW-1:0]       o_repeat_count,
    output logic                 o_train_error,
    output logic                 o_end
);
    localparam logic [3:0] MSG_START_REQ  = 4'b0001;
    localparam logic [3:0] MSG_START_RESP = 4'b0010;
    localparam logic [3:0] MSG_END_REQ    = 4'b0011;
    localparam logic [3:0] MSG_END_RESP   = 4'b0100;
    localparam logic [3:0] MSG_DEG_REQ    = 4'b0101;
    localparam logic [3:0] MSG_DEG_RESP   = 4'b0110;

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [NUM_LANES-1:0] LO_HALF =
        {{(NUM_LANES/2){1'b0}}, {(NUM_LANES/2){1'b1}}};

    typedef enum logic [3:0] {
        IDLE, WAIT_START, BUSY_START, START_RESP, WAIT_REQ, CHECK, REPEAT,
        BUSY_DEG, DEG_RESP, BUSY_END, END_RESP, DONE, ERROR
    } state_t;

    state_t         state, nxt;
    logic [TW-1:0]  tmo_cnt;
    logic [1:0]     cap_code;
    logic           accepted;
    logic           timed_out;
    logic [NUM_LANES-1:0] req_mask;

    // Lane enables implied by the width code captured with the degrade request.
    always_comb begin
        case (cap_code)
            2'b11:   req_mask = '1;
            2'b01:   req_mask = LO_HALF;
            2'b10:   req_mask = ~LO_HALF;
            default: req_mask = '0;
        endcase
    end

    // Next-state decision: enable low, then timeout, then message decode.
    always_comb begin
        timed_out = (TIMEOUT_CYCLES != 0) && (state == WAIT_START || state == WAIT_REQ)
                    && (tmo_cnt == TMO_LAST);
        nxt = state;
        if (!i_enable) begin
            nxt = IDLE;
        end else if (timed_out) begin
            nxt = ERROR;
        end else begin
            case (state)
                IDLE:       nxt = WAIT_START;
                WAIT_START: if (sb.i_msg_valid && sb.i_rx_sb_message == MSG_START_REQ) nxt = BUSY_START;
                BUSY_START: if (!sb.i_busy_sideband) nxt = START_RESP;
                START_RESP: if (sb.i_falling_edge_busy) nxt = WAIT_REQ;
                WAIT_REQ: begin
                    if (sb.i_msg_valid && sb.i_rx_sb_message == MSG_DEG_REQ)
                        nxt = CHECK;
                    else if (sb.i_msg_valid && sb.i_rx_sb_message == MSG_END_REQ && accepted)
                        nxt = BUSY_END;
                end
                CHECK: begin
                    if (cap_code == 2'b00)                          nxt = ERROR;
                    else if ((i_lane_pass & req_mask) == req_mask)  nxt = BUSY_DEG;
                    else if (o_repeat_count < RCW'(MAX_REPEATS))    nxt = REPEAT;
                    else                                            nxt = ERROR;
                end
                REPEAT:     if (i_done_repeater) nxt = WAIT_REQ;
                BUSY_DEG:   if (!sb.i_busy_sideband) nxt = DEG_RESP;
                DEG_RESP:   if (sb.i_falling_edge_busy) nxt = WAIT_REQ;
                BUSY_END:   if (!sb.i_busy_sideband) nxt = END_RESP;
                END_RESP:   if (sb.i_falling_edge_busy) nxt = DONE;
                DONE:       nxt = DONE;
                ERROR:      nxt = ERROR;
                default:    nxt = IDLE;
            endcase
        end
    end

    // State, timeout counter, captured request and outputs, all registered
    // from the next state so every output lines up with the current state.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state              <= IDLE;
            tmo_cnt            <= '0;
            cap_code           <= 2'b00;
            accepted           <= 1'b0;
            sb.o_valid_out     <= 1'b0;
            sb.o_tx_sb_message <= 4'b0000;
            o_start_repeater   <= 1'b0;
            o_functional_lanes <= 2'b11;
            o_lane_mask        <= '1;
            o_repeat_count     <= '0;
            o_train_error      <= 1'b0;
            o_end              <= 1'b0;
        end else begin
            state   <= nxt;
            tmo_cnt <= (nxt == state && (state == WAIT_START || state == WAIT_REQ))
                       ? tmo_cnt + 1'b1 : '0;

            case (nxt)
                START_RESP: begin sb.o_valid_out <= 1'b1; sb.o_tx_sb_message <= MSG_START_RESP; end
                DEG_RESP:   begin sb.o_valid_out <= 1'b1; sb.o_tx_sb_message <= MSG_DEG_RESP;   end
                END_RESP:   begin sb.o_valid_out <= 1'b1; sb.o_tx_sb_message <= MSG_END_RESP;   end
                default:    begin sb.o_valid_out <= 1'b0; sb.o_tx_sb_message <= 4'b0000;        end
            endcase
            o_start_repeater <= (nxt == REPEAT) && (state != REPEAT);
            o_end            <= (nxt == DONE);
            o_train_error    <= (nxt == ERROR);

            if (!i_enable) begin
                accepted           <= 1'b0;
                o_repeat_count     <= '0;
                o_functional_lanes <= 2'b11;
                o_lane_mask        <= '1;
            end else begin
                if (state == WAIT_REQ && nxt == CHECK)
                    cap_code <= sb.i_rx_functional_lanes;
                if (state == CHECK && nxt == BUSY_DEG) begin
                    o_functional_lanes <= cap_code;
                    o_lane_mask        <= req_mask;
                    accepted           <= 1'b1;
                end
                if (state == REPEAT && nxt == WAIT_REQ) begin
                    o_repeat_count <= o_repeat_count + 1'b1;
                    accepted       <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mbinit_repairmb_responder.sv
// Bench for the REPAIRMB responder. A transaction-level model decides the
// outcome of every request: response, repeater run or train error.
module tb_mbinit_repairmb_responder;
    localparam int NL  = 16;
    localparam int MR  = 2;
    localparam int TO  = 16;
    localparam int RCW = $clog2(MR + 1);

    localparam logic [3:0] START_REQ = 4'b0001, START_RESP = 4'b0010;
    localparam logic [3:0] END_REQ   = 4'b0011, END_RESP   = 4'b0100;
    localparam logic [3:0] DEG_REQ   = 4'b0101, DEG_RESP   = 4'b0110;

    logic           CLK = 1'b0;
    logic           rst;
    logic           i_enable;
    logic [NL-1:0]  i_lane_pass;
    logic           i_done_repeater;
    logic           o_start_repeater;
    logic [1:0]     o_functional_lanes;
    logic [NL-1:0]  o_lane_mask;
    logic [RCW-1:0] o_repeat_count;
    logic           o_train_error;
    logic           o_end;

    mbinit_repairmb_responder_if sb();

    mbinit_repairmb_responder #(.NUM_LANES(NL), .MAX_REPEATS(MR), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .rst(rst), .i_enable(i_enable), .sb(sb),
        .i_lane_pass(i_lane_pass), .i_done_repeater(i_done_repeater),
        .o_start_repeater(o_start_repeater), .o_functional_lanes(o_functional_lanes),
        .o_lane_mask(o_lane_mask), .o_repeat_count(o_repeat_count),
        .o_train_error(o_train_error), .o_end(o_end)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Transmit log and repeater pulse count, sampled mid-cycle.
    logic [3:0] tx_log[$];
    int         rep_pulses = 0;
    logic       prev_valid = 1'b0;
    always @(negedge CLK) begin
        if (sb.o_valid_out === 1'b1 && prev_valid !== 1'b1) tx_log.push_back(sb.o_tx_sb_message);
        prev_valid <= sb.o_valid_out;
        if (o_start_repeater === 1'b1) rep_pulses++;
    end

    // Model state: repeater runs used, accepted flag, session end conditions.
    int m_rep;
    bit m_acc, m_err, m_done;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NL-1:0] lanes_of(input logic [1:0] c);
        logic [NL-1:0] lo;
        lo = (NL'(1) << (NL/2)) - NL'(1);
        case (c)
            2'b11:   return '1;
            2'b01:   return lo;
            2'b10:   return lo << (NL/2);
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [3:0] m, input logic [1:0] code);
        sb.i_rx_sb_message       = m;
        sb.i_rx_functional_lanes = code;
        sb.i_msg_valid           = 1'b1;
        tick();
        sb.i_msg_valid           = 1'b0;
        sb.i_rx_sb_message       = 4'($urandom);
        sb.i_rx_functional_lanes = 2'($urandom);
    endtask

    // Called while the DUT sits in a BUSY state; holds busy a random while.
    task automatic expect_resp(input logic [3:0] exp, input string tag);
        int n, k;
        n = $urandom_range(0, 2);
        sb.i_busy_sideband = 1'b1;
        sb.i_falling_edge_busy = (n > 0);
        repeat (n) tick();
        sb.i_busy_sideband = 1'b0;
        sb.i_falling_edge_busy = 1'b0;
        k = 0;
        while (sb.o_valid_out !== 1'b1 && k < 8) begin tick(); k++; end
        chk({tag, " latency"}, k, 1);
        chk({tag, " valid"}, sb.o_valid_out, 1);
        chk({tag, " msg"}, sb.o_tx_sb_message, exp);
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk({tag, " held"}, {sb.o_valid_out, sb.o_tx_sb_message}, {1'b1, exp});
        end
        sb.i_falling_edge_busy = 1'b1;
        tick();
        sb.i_falling_edge_busy = 1'b0;
        chk({tag, " released"}, sb.o_valid_out, 0);
    endtask

    task automatic session_start();
        i_enable = 1'b0;
        tick();
        m_rep = 0; m_acc = 0; m_err = 0; m_done = 0;
        i_enable = 1'b1;
        tick();
        repeat ($urandom_range(0, 3)) tick();
        send(START_REQ, 2'($urandom));
        expect_resp(START_RESP, "start_resp");
    endtask

    task automatic degrade(input logic [1:0] code, input logic [NL-1:0] pass);
        logic [NL-1:0] req;
        int before_tx, before_rep;
        req = lanes_of(code);
        before_tx = tx_log.size();
        before_rep = rep_pulses;
        i_lane_pass = pass;
        send(DEG_REQ, code);
        tick();
        i_lane_pass = NL'($urandom);
        if (code == 2'b00 || ((pass & req) != req && m_rep >= MR)) begin
            chk("error flag", o_train_error, 1);
            repeat (2) tick();
            chk("error sticky", o_train_error, 1);
            chk("error no tx", tx_log.size() - before_tx, 0);
            chk("error no repeater", rep_pulses - before_rep, 0);
            m_err = 1;
        end else if ((pass & req) == req) begin
            chk("accept no error", o_train_error, 0);
            expect_resp(DEG_RESP, "deg_resp");
            m_acc = 1;
            chk("accept mask", o_lane_mask, req);
            chk("accept func", o_functional_lanes, code);
            chk("accept count", o_repeat_count, m_rep);
        end else begin
            chk("repeater start", o_start_repeater, 1);
            repeat ($urandom_range(0, 3)) tick();
            i_done_repeater = 1'b1;
            tick();
            i_done_repeater = 1'b0;
            m_rep++;
            m_acc = 0;
            chk("repeater single pulse", rep_pulses - before_rep, 1);
            chk("repeat count", o_repeat_count, m_rep);
            chk("repeat no tx", tx_log.size() - before_tx, 0);
        end
    endtask

    task automatic end_req();
        int before_tx;
        before_tx = tx_log.size();
        send(END_REQ, 2'($urandom));
        if (m_acc) begin
            expect_resp(END_RESP, "end_resp");
            chk("o_end", o_end, 1);
            m_done = 1;
        end else begin
            repeat (2) tick();
            chk("early end no tx", tx_log.size() - before_tx, 0);
            chk("early end no end", o_end, 0);
            chk("early end no error", o_train_error, 0);
        end
    endtask

    initial begin
        int idx, deg_cnt;
        bit ign_used;
        rst = 1'b1; i_enable = 1'b1; i_lane_pass = '1; i_done_repeater = 1'b0;
        sb.i_busy_sideband = 1'b0; sb.i_falling_edge_busy = 1'b0;
        sb.i_rx_sb_message = START_REQ; sb.i_msg_valid = 1'b1; sb.i_rx_functional_lanes = 2'b11;

        // Reset wins over enable and a valid request.
        repeat (2) tick();
        chk("reset valid", sb.o_valid_out, 0);
        chk("reset msg", sb.o_tx_sb_message, 0);
        chk("reset start_rep", o_start_repeater, 0);
        chk("reset train_error", o_train_error, 0);
        chk("reset end", o_end, 0);
        chk("reset func", o_functional_lanes, 2'b11);
        chk("reset mask", o_lane_mask, 16'hFFFF);
        chk("reset count", o_repeat_count, 0);
        sb.i_msg_valid = 1'b0;
        rst = 1'b0;

        // Clean path.
        idx = tx_log.size();
        session_start();
        degrade(2'b11, '1);
        end_req();
        chk("clean tx count", tx_log.size() - idx, 3);
        if (tx_log.size() >= idx + 3) begin
            chk("clean tx0", tx_log[idx],     START_RESP);
            chk("clean tx1", tx_log[idx + 1], DEG_RESP);
            chk("clean tx2", tx_log[idx + 2], END_RESP);
        end
        chk("clean mask", o_lane_mask, 16'hFFFF);
        chk("clean count", o_repeat_count, 0);

        // Repeat then accept on the lower half.
        idx = rep_pulses;
        session_start();
        degrade(2'b01, 16'hFFF7);
        degrade(2'b01, 16'h00FF);
        chk("rpt pulses", rep_pulses - idx, 1);
        chk("rpt mask", o_lane_mask, 16'h00FF);
        chk("rpt func", o_functional_lanes, 2'b01);
        chk("rpt count", o_repeat_count, 1);
        end_req();

        // Repeat exhaustion with lane 9 stuck.
        idx = rep_pulses;
        deg_cnt = tx_log.size();
        session_start();
        repeat (3) degrade(2'b10, 16'hFDFF);
        chk("exhaust pulses", rep_pulses - idx, 2);
        chk("exhaust error", o_train_error, 1);
        chk("exhaust no deg resp", tx_log.size() - deg_cnt, 1);

        // Illegal width code.
        session_start();
        degrade(2'b00, '1);

        // Early end is ignored, then the normal path completes.
        session_start();
        end_req();
        degrade(2'b11, '1);
        end_req();

        // Request timeout after start_resp.
        session_start();
        repeat (TO - 1) tick();
        chk("timeout not yet", o_train_error, 0);
        tick();
        chk("timeout error", o_train_error, 1);
        chk("timeout no tx", sb.o_valid_out, 0);

        // Abort while degrade response is on the wire.
        session_start();
        degrade(2'b01, 16'hFFF7);
        degrade(2'b01, '1);
        i_lane_pass = '1;
        send(DEG_REQ, 2'b10);
        repeat (2) tick();
        chk("abort in resp", {sb.o_valid_out, sb.o_tx_sb_message}, {1'b1, DEG_RESP});
        chk("abort pre func", o_functional_lanes, 2'b10);
        i_enable = 1'b0;
        tick();
        chk("abort valid", sb.o_valid_out, 0);
        chk("abort msg", sb.o_tx_sb_message, 0);
        chk("abort func", o_functional_lanes, 2'b11);
        chk("abort mask", o_lane_mask, 16'hFFFF);
        chk("abort count", o_repeat_count, 0);
        chk("abort flags", {o_train_error, o_end, o_start_repeater}, 0);
        i_enable = 1'b1;
        tick();
        send(START_REQ, 2'b11);
        expect_resp(START_RESP, "restart_resp");

        // Randomized sessions against the model.
        for (int s = 0; s < 12; s++) begin
            session_start();
            ign_used = 0;
            for (int op = 0; op < 6 && !m_err && !m_done; op++) begin
                int r;
                logic [NL-1:0] pass;
                repeat ($urandom_range(0, 2)) tick();
                r = $urandom_range(0, 9);
                if (r >= 7 && (m_acc || !ign_used)) begin
                    if (!m_acc) ign_used = 1;
                    end_req();
                end else begin
                    pass = '1;
                    if ($urandom_range(0, 2) == 0) pass[$urandom_range(0, NL - 1)] = 1'b0;
                    degrade((r == 0) ? 2'b00 : 2'($urandom_range(1, 3)), pass);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
